// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkt_reader
//  Description : Read-side controller for sync_fifo. Drains length-prefixed
//                packets (header word = payload length N, then N words) and
//                presents the payload on a valid/ready stream with m_last.
//                Headers are consumed internally; zero-length headers raise a
//                one-cycle err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_pkt_reader #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          empty,
    input  logic [DW-1:0] dout,
    output logic          rd_en,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          err,
    output logic          busy,
    output logic [CW-1:0] pkt_cnt
);

    typedef enum logic [1:0] {
        HDR_REQ  = 2'd0,
        HDR_WAIT = 2'd1,
        PAY      = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   w_rem_nxt;
    logic            r_err;
    logic            w_hdr_zero;

    // Single in-flight slot: a payload read issued last cycle, with its tag
    logic            r_infl;
    logic            r_infl_last;
    logic            w_pay_issue;
    logic            w_last_issue;

    // Two-entry output buffer of {data, last}
    logic [DW-1:0]   r_buf_data [2];
    logic [1:0]      r_buf_last;
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;
    logic [CW-1:0]   r_pkt_cnt;

    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_credit;

    assign w_pop    = (r_count != 2'd0) && m_ready;
    // pop implies count >= 1, so this never goes negative
    assign w_occ    = {1'b0, r_count} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_credit = (w_occ < 3'd2);
    assign w_last_issue = (r_rem == DW'(1));

    // Next-state, read issue and length bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        rd_en       = 1'b0;
        w_pay_issue = 1'b0;
        w_hdr_zero  = 1'b0;
        case (r_state)
            HDR_REQ: begin
                if (!empty) begin
                    rd_en       = 1'b1;
                    w_state_nxt = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (dout == '0) begin
                    w_hdr_zero  = 1'b1;
                    w_state_nxt = HDR_REQ;
                end else begin
                    w_rem_nxt   = dout;
                    w_state_nxt = PAY;
                end
            end
            PAY: begin
                if (!empty && w_credit) begin
                    rd_en       = 1'b1;
                    w_pay_issue = 1'b1;
                    w_rem_nxt   = r_rem - DW'(1);
                    if (w_last_issue) begin
                        w_state_nxt = HDR_REQ;
                    end
                end
            end
            default: w_state_nxt = HDR_REQ;
        endcase
        // A pop during the reset cycle would lose a word, so hold off
        if (!rstn) begin
            rd_en       = 1'b0;
            w_pay_issue = 1'b0;
        end
    end

    // FSM state, remaining length and registered error pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= HDR_REQ;
            r_rem   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_err   <= w_hdr_zero;
        end
    end

    // In-flight slot carries the last tag alongside the pending read
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_infl      <= w_pay_issue;
            r_infl_last <= w_last_issue;
        end
    end

    // Output buffer: write on returning payload, pop on accepted beat
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= 2'b00;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (r_infl) begin
                r_buf_data[r_wr_ptr] <= dout;
                r_buf_last[r_wr_ptr] <= r_infl_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_infl, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Delivered-packet counter, bumped when a last beat is accepted
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pkt_cnt <= '0;
        end else if (w_pop && r_buf_last[r_rd_ptr]) begin
            r_pkt_cnt <= r_pkt_cnt + CW'(1);
        end
    end

    assign m_valid = (r_count != 2'd0);
    assign m_data  = r_buf_data[r_rd_ptr];
    assign m_last  = r_buf_last[r_rd_ptr];
    assign err     = r_err;
    assign pkt_cnt = r_pkt_cnt;
    assign busy    = (r_state == HDR_WAIT) || (r_state == PAY) || (r_count != 2'd0);

endmodule
`default_nettype wire

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side controller for `sync_fifo` (16-bit, 1-cycle registered read).

- Drains length-prefixed packets from the FIFO: one header word giving the payload length N, then N payload words.
- Presents the payload on a valid/ready master stream with an end-of-packet flag.
- Headers are consumed internally and never forwarded.
- Sits between the FIFO read port and downstream packet consumers, and never over-reads an empty FIFO.

## Interface
Parameters:
- `DW`, 16, data width; must match `sync_fifo` data width.
- `CW`, 16, width of the `pkt_cnt` statistics counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `empty`  in  1  FIFO empty flag.
- `dout`  in  DW  FIFO read data; valid the cycle after `rd_en` is sampled high.
- `rd_en`  out  1  FIFO pop request.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DW  payload word.
- `m_last`  out  1  marks the final payload word of a packet.
- `err`  out  1  one-cycle pulse when a zero-length header is consumed.
- `busy`  out  1  high while in HDR_WAIT or PAY, or while the output buffer is non-empty.
- `pkt_cnt`  out  CW  count of packets fully delivered (last beat accepted); wraps modulo 2^CW.

## Operation
Issue-side FSM:
- HDR_REQ (reset state):
  - If `!empty`, assert `rd_en` and go to HDR_WAIT.
  - Header reads need no output-buffer credit.
- HDR_WAIT: capture `dout` as len.
  - len == 0: pulse `err`, go to HDR_REQ.
  - Otherwise: set rem = len, go to PAY.
- PAY:
  - Assert `rd_en` when `!empty` and credit is available.
  - Each issued read decrements rem. The read issued with rem == 1 is tagged last.
  - After that read, go to HDR_REQ.
- Payload reads are tagged {last} at issue. The tag travels with the 1-cycle in-flight slot.

Output buffer:
- 2-entry FIFO of {data, last}.
- Written when an in-flight payload read returns.
- Popped on `m_valid && m_ready`.

Credit rule:
- Issue is allowed iff occupancy + inflight − pop_this_cycle < 2.
- This guarantees there is never an overflow and sustains 1 word/cycle.

Other rules:
- `rd_en` is never asserted while `empty` is high. This is an invariant under all conditions.
- `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
- `pkt_cnt` increments on the cycle a beat with `m_last` = 1 is accepted.
- len is an unsigned DW-bit value. The maximum packet is 2^DW − 1 words.
- rem is DW bits wide and never underflows.
- The header of packet k+1 may be read while packet k's tail is still in the output buffer. Ordering is preserved.

## Timing
Reset values (synchronous `rstn` = 0; takes effect at the next edge):
- `rd_en` = 0, `m_valid` = 0, `m_data` = 0, `m_last` = 0, `err` = 0, `busy` = 0, `pkt_cnt` = 0.
- FSM = HDR_REQ, buffer empty, in-flight slot cleared.

Reset mid-packet:
- Any in-flight read data is discarded.
- The next word popped after reset is treated as a header.

Latency, with the header `rd_en` in cycle T:
- Capture in T+1.
- First payload `rd_en` at the earliest in T+2.
- Data arrives in T+3.
- `m_valid` at T+4.
- Per-packet overhead is 2 idle read cycles.

Throughput:
- With `m_ready` = 1 and the FIFO non-empty, payload beats are back-to-back, 1 per cycle.

Empty mid-packet:
- PAY waits with `rd_en` = 0 for any duration.
- Reads resume the cycle after `empty` falls.

`m_valid` behaviour:
- Rises only from the buffer being non-empty.
- Does not depend combinationally on `m_ready`.

`err` is registered: it is high in the cycle after HDR_WAIT.

## Test plan
- FIFO holds 3, A1, A2, A3; `m_ready` = 1 → beats A1, A2, A3 on consecutive cycles, `m_last` only on A3, `pkt_cnt` = 1, `err` never high, no `rd_en` while `empty`.
- Header 4, four payload words, `m_ready` low for 6 cycles starting at the first `m_valid` → at most 2 payload reads outstanding, `rd_en` stalls, `m_data` stable, and all 4 words are delivered in order after release.
- FIFO holds 0, 1, B1 → `err` pulses exactly one cycle, only B1 is output with `m_last` = 1, `pkt_cnt` = 1.
- Header 5 with only 2 payload words, then `empty` for 10 cycles, then 3 more words → `rd_en` = 0 during the gap, 5 beats total, `m_last` on the 5th.
- Assert `rstn` = 0 for one cycle after 2 of 6 payload words are output, then push 2, C1, C2 → all outputs return to 0, and the next FIFO word is treated as a header.
- FIFO prefilled with 8, D1..D8, 2, E1, E2; `m_ready` = 1 → D1..D8 in 8 consecutive cycles, E1 `m_valid` exactly 3 cycles after D8, `pkt_cnt` = 2.
